simd_add_arbiter: RTL and testbench

Round-robin front end that shares one packed-SIMD add/subtract unit among `NREQ` requesters. Each requester presents two 16-bit operands, a lane mode and an add/sub flag over a valid/ready handshake. The arbiter grants one request per cycle into a single-entry registered result stage, tagged with the requester index. It sits between the vector issue ports and the writeback mux, and is the only path into the SIMD adder.

---
 rtl/simd_pkg.sv | 21 ++
 rtl/simd_lane_alu.sv | 38 +++
 rtl/simd_add_arbiter.sv | 87 ++++++++
 tb/tb_simd_add_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared types for the SIMD add/sub front end: lane modes, data width and
// the request bundle carried from the grant mux into the lane ALU.
package simd_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    MODE_Q    = 2'b00,  // four 4-bit lanes
    MODE_O    = 2'b01,  // two 8-bit lanes
    MODE_H    = 2'b10,  // one 16-bit lane
    MODE_RSVD = 2'b11   // treated as MODE_H
  } mode_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    mode_e             mode;
    logic              sub;
  } simd_req_t;

endpackage

// File: rtl/simd_lane_alu.sv
// Combinational packed-SIMD add/sub. Built as a chain of 4-bit nibble adders;
// the mode decides at which nibbles the chain restarts with the lane carry-in,
// so no carry or borrow leaks across a lane boundary.
module simd_lane_alu
  import simd_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  mode_e             mode,
  input  logic              sub,
  output logic [DATA_W-1:0] y
);

  localparam int NIB = DATA_W / 4;

  logic [NIB-1:0]    lane_start;
  logic [DATA_W-1:0] b_eff;
  logic              carry;
  logic [4:0]        nsum;

  // Per-nibble add with the carry chain broken at each lane's first nibble;
  // subtraction is A + ~B + 1 with the +1 injected at every lane start.
  always_comb begin
    b_eff = sub ? ~b : b;
    for (int i = 0; i < NIB; i++)
      lane_start[i] = (i == 0) || (mode == MODE_Q) || ((mode == MODE_O) && (i % 2 == 0));
    y     = '0;
    carry = sub;
    nsum  = '0;
    for (int i = 0; i < NIB; i++) begin
      if (lane_start[i]) carry = sub;
      nsum       = {1'b0, a[4*i +: 4]} + {1'b0, b_eff[4*i +: 4]} + {4'b0, carry};
      y[4*i +: 4] = nsum[3:0];
      carry      = nsum[4];
    end
  end

endmodule

// File: rtl/simd_add_arbiter.sv
// Round-robin front end sharing one SIMD add/sub unit among NREQ requesters,
// feeding a single-entry result register with pass-through on res_ready.
module simd_add_arbiter
  import simd_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req_valid,
  output logic [NREQ-1:0]                req_ready,
  input  logic [NREQ-1:0][DATA_W-1:0]    req_a,
  input  logic [NREQ-1:0][DATA_W-1:0]    req_b,
  input  logic [NREQ-1:0][1:0]           req_mode,
  input  logic [NREQ-1:0]                req_sub,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [DATA_W-1:0]              res_data,
  output logic [IDW-1:0]                 res_id
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

  logic                stage_free;
  logic                grant;
  logic [2*NREQ-1:0]   dbl;
  logic [NREQ-1:0]     rot;
  logic [IDW-1:0]      enc;
  logic [IDW:0]        sum;
  logic [IDW-1:0]      gnt_id;
  logic [IDW-1:0]      rr_ptr;
  simd_req_t           sel;
  logic [DATA_W-1:0]   alu_y;

  assign stage_free = !res_valid || res_ready;

  // Rotate valids so rr_ptr sits at bit 0, pick the lowest set bit, then add
  // rr_ptr back (mod NREQ) to recover the absolute requester index.
  always_comb begin
    dbl = {req_valid, req_valid} >> rr_ptr;
    rot = dbl[NREQ-1:0];
    enc = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (rot[k]) enc = IDW'(k);
    sum    = {1'b0, rr_ptr} + {1'b0, enc};
    gnt_id = (sum >= NREQ_W) ? IDW'(sum - NREQ_W) : sum[IDW-1:0];
    // rst gating keeps req_ready low for the whole reset window
    grant     = (|req_valid) && stage_free && !rst;
    req_ready = grant ? (NREQ'(1) << gnt_id) : '0;
  end

  // Grant mux: route the winning requester's operands to the single ALU.
  always_comb begin
    sel.a    = req_a[gnt_id];
    sel.b    = req_b[gnt_id];
    sel.mode = mode_e'(req_mode[gnt_id]);
    sel.sub  = req_sub[gnt_id];
  end

  simd_lane_alu u_alu (
    .a    (sel.a),
    .b    (sel.b),
    .mode (sel.mode),
    .sub  (sel.sub),
    .y    (alu_y)
  );

  // Result register and round-robin pointer; pointer only moves on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      rr_ptr    <= '0;
    end else if (grant) begin
      res_valid <= 1'b1;
      res_data  <= alu_y;
      res_id    <= gnt_id;
      rr_ptr    <= (gnt_id == LAST) ? '0 : gnt_id + 1'b1;
    end else if (stage_free) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_simd_add_arbiter.sv
// Scoreboard bench: stimulus pushes hand-computed results as grants are
// expected; a negedge monitor pops and compares on every accepted result.
module tb_simd_add_arbiter;
  import simd_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [3:0]        req_valid = '0;
  logic [3:0]        req_ready;
  logic [3:0][15:0]  req_a = '0;
  logic [3:0][15:0]  req_b = '0;
  logic [3:0][1:0]   req_mode = '0;
  logic [3:0]        req_sub = '0;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [15:0]       res_data;
  logic [1:0]        res_id;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [17:0] sb_q[$];

  simd_add_arbiter #(.NREQ(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_mode(req_mode), .req_sub(req_sub),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] m, input logic s);
    req_a[i] = a; req_b[i] = b; req_mode[i] = m; req_sub[i] = s;
  endtask

  // Called at posedge+1 with inputs settled: check grant vector, queue the
  // expected result, advance one cycle.
  task automatic tick_chk(input logic [3:0] exp_rdy, input logic [15:0] exp_d);
    logic [1:0] id;
    #1;
    chk("req_ready", {28'b0, req_ready}, {28'b0, exp_rdy});
    if (exp_rdy != 4'b0) begin
      id = 2'd0;
      for (int i = 0; i < 4; i++) if (exp_rdy[i]) id = 2'(i);
      sb_q.push_back({id, exp_d});
    end
    @(posedge clk); #1;
  endtask

  // Monitor: every result accepted at the next edge is compared in order.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_result: got id %0d data %h with nothing expected", res_id, res_data);
      end else begin
        logic [17:0] e;
        e = sb_q.pop_front();
        chk("res_data", {16'b0, res_data}, {16'b0, e[15:0]});
        chk("res_id", {30'b0, res_id}, {30'b0, e[17:16]});
      end
    end
  end

  initial begin
    // reset state, with requests present to prove req_ready stays low
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'hF;
    #1;
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_res_data", {16'b0, res_data}, 32'h0);
    chk("rst_res_id", {30'b0, res_id}, 32'd0);
    chk("rst_req_ready", {28'b0, req_ready}, 32'd0);
    req_valid = 4'h0;
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // directed arithmetic, one requester at a time
    set_req(0, 16'h1234, 16'h0FFF, 2'b10, 1'b0); req_valid = 4'b0001; tick_chk(4'b0001, 16'h2233);
    set_req(1, 16'h000F, 16'h0001, 2'b00, 1'b0); req_valid = 4'b0010; tick_chk(4'b0010, 16'h0000);
    set_req(2, 16'h0100, 16'h0001, 2'b01, 1'b1); req_valid = 4'b0100; tick_chk(4'b0100, 16'h01FF);
    set_req(3, 16'h0100, 16'h0001, 2'b10, 1'b1); req_valid = 4'b1000; tick_chk(4'b1000, 16'h00FF);
    set_req(0, 16'h1000, 16'h0001, 2'b00, 1'b1); req_valid = 4'b0001; tick_chk(4'b0001, 16'h100F);
    set_req(1, 16'h00FF, 16'h0001, 2'b11, 1'b0); req_valid = 4'b0010; tick_chk(4'b0010, 16'h0100);
    // pointer is at 2; search must wrap to requester 0
    set_req(0, 16'h8888, 16'h8888, 2'b01, 1'b0); req_valid = 4'b0001; tick_chk(4'b0001, 16'h1010);

    // single requester 2 continuously valid
    set_req(2, 16'h0001, 16'h0001, 2'b10, 1'b0); req_valid = 4'b0100;
    repeat (3) tick_chk(4'b0100, 16'h0002);

    // round robin: operands 0x0010+i plus 0x0100 -> 0x0110+i
    for (int i = 0; i < 4; i++) set_req(i, 16'h0010 + 16'(i), 16'h0100, 2'b10, 1'b0);
    req_valid = 4'b1000; tick_chk(4'b1000, 16'h0113);   // brings pointer to 0
    req_valid = 4'b1111;
    tick_chk(4'b0001, 16'h0110);
    tick_chk(4'b0010, 16'h0111);
    tick_chk(4'b0100, 16'h0112);
    tick_chk(4'b1000, 16'h0113);
    tick_chk(4'b0001, 16'h0110);
    tick_chk(4'b0010, 16'h0111);

    // backpressure: pointer at 2, only requester 1 asks -> granted, then held
    req_valid = 4'b0010; tick_chk(4'b0010, 16'h0111);
    res_ready = 1'b0; req_valid = 4'b1111;
    repeat (3) begin
      #1;
      chk("hold_valid", {31'b0, res_valid}, 32'd1);
      chk("hold_data", {16'b0, res_data}, 32'h0111);
      chk("hold_id", {30'b0, res_id}, 32'd1);
      #(-1+1);
      tick_chk(4'b0000, 16'h0000);
    end
    res_ready = 1'b1;
    tick_chk(4'b0100, 16'h0112);   // pass-through grant in the release cycle

    // async reset while a result is held
    res_ready = 1'b0; req_valid = 4'b0000;
    #2;
    chk("pre_rst_valid", {31'b0, res_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, res_valid}, 32'd0);
    chk("async_rst_ready", {28'b0, req_ready}, 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    res_ready = 1'b1; req_valid = 4'b1111;
    tick_chk(4'b0001, 16'h0110);
    req_valid = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 32'd0);
    chk("idle_valid", {31'b0, res_valid}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
